// File: rtl/fxp_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fxp_mac_pipe
// Description : Two-stage signed fixed-point multiply-accumulate pipeline with
//               valid/ready handshakes on both sides and saturating arithmetic.
//               S1 registers the operand pair and acc_en; S2 registers the
//               result and its overflow flag. The accumulator is updated on
//               the same edge S2 is written.
// Config      : FXP_MAC_PIPE_ROUND_EN (optional define)
//                 defined   -> round half up before the fractional shift
//                 undefined -> truncate (floor toward -infinity)
// Ports       : clk      in   clock, rising edge
//               rst_n    in   asynchronous active-low reset
//               in_val   in   operand pair valid
//               in_rdy   out  operand pair can be accepted this cycle
//               in0/in1  in   signed fixed-point operands (NBITS, DBITS frac)
//               acc_en   in   1 = add product to accumulator, 0 = load product
//               out_val  out  result valid
//               out_rdy  in   consumer accepts result
//               out      out  signed fixed-point result
//               ovf      out  result was saturated (qualified by out_val)
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_mac_pipe #(
  parameter int NBITS = 8,
  parameter int DBITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             acc_en,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out,
  output logic             ovf
);

  // Product path is one bit wider than the full product so the rounding
  // constant can never wrap it.
  localparam int PW = 2*NBITS + 1;
  localparam int SW = NBITS + 1;

  localparam logic signed [PW-1:0]    P_MAX = {{(PW-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [PW-1:0]    P_MIN = {{(PW-NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};
  localparam logic signed [SW-1:0]    S_MAX = {2'b00, {(NBITS-1){1'b1}}};
  localparam logic signed [SW-1:0]    S_MIN = {2'b11, {(NBITS-1){1'b0}}};
  localparam logic        [NBITS-1:0] N_MAX = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic        [NBITS-1:0] N_MIN = {1'b1, {(NBITS-1){1'b0}}};

  // Stage 1
  logic                    s1_val_q, s1_val_d;
  logic signed [NBITS-1:0] a_q, a_d;
  logic signed [NBITS-1:0] b_q, b_d;
  logic                    acc_en_q, acc_en_d;

  // Stage 2 and accumulator
  logic                    s2_val_q, s2_val_d;
  logic [NBITS-1:0]        out_q, out_d;
  logic                    ovf_q, ovf_d;
  logic [NBITS-1:0]        acc_q, acc_d;

  // Handshake
  logic s1_adv;
  logic in_fire;

  assign s1_adv  = s1_val_q & (~s2_val_q | out_rdy);
  assign in_rdy  = rst_n & (~s1_val_q | s1_adv);
  assign in_fire = in_val & in_rdy;

  // Arithmetic
  logic signed [2*NBITS-1:0] prod;
  logic signed [PW-1:0]      prod_x;
  logic signed [PW-1:0]      rnd;
  logic signed [PW-1:0]      scaled;
  logic                      p_hi, p_lo;
  logic [NBITS-1:0]          p_sat;
  logic signed [SW-1:0]      sum;
  logic                      s_hi, s_lo;
  logic [NBITS-1:0]          s_sat;
  logic [NBITS-1:0]          res;
  logic                      res_ovf;

  assign prod   = a_q * b_q;
  assign prod_x = {prod[2*NBITS-1], prod};

`ifdef FXP_MAC_PIPE_ROUND_EN
  generate
    if (DBITS > 0) begin : g_rnd_on
      assign rnd = {{(PW-1){1'b0}}, 1'b1} << (DBITS-1);
    end else begin : g_rnd_zero
      assign rnd = '0;
    end
  endgenerate
`else
  assign rnd = '0;
`endif

  // Arithmetic shift floors toward -infinity; with rnd added it rounds half up.
  assign scaled = (prod_x + rnd) >>> DBITS;

  assign p_hi  = (scaled > P_MAX);
  assign p_lo  = (scaled < P_MIN);
  assign p_sat = p_hi ? N_MAX : (p_lo ? N_MIN : scaled[NBITS-1:0]);

  // One guard bit is enough for the sum of two NBITS signed values.
  assign sum   = {acc_q[NBITS-1], acc_q} + {p_sat[NBITS-1], p_sat};
  assign s_hi  = (sum > S_MAX);
  assign s_lo  = (sum < S_MIN);
  assign s_sat = s_hi ? N_MAX : (s_lo ? N_MIN : sum[NBITS-1:0]);

  assign res     = acc_en_q ? s_sat : p_sat;
  assign res_ovf = p_hi | p_lo | (acc_en_q & (s_hi | s_lo));

  // Next-state
  always_comb begin
    s1_val_d = s1_val_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_en_d = acc_en_q;
    s2_val_d = s2_val_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;

    if (in_fire) begin
      s1_val_d = 1'b1;
      a_d      = in0;
      b_d      = in1;
      acc_en_d = acc_en;
    end else if (s1_adv) begin
      s1_val_d = 1'b0;
    end

    if (s1_adv) begin
      s2_val_d = 1'b1;
      out_d    = res;
      ovf_d    = res_ovf;
      acc_d    = res;
    end else if (s2_val_q && out_rdy) begin
      s2_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_en_q <= 1'b0;
      s2_val_q <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
    end else begin
      s1_val_q <= s1_val_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_en_q <= acc_en_d;
      s2_val_q <= s2_val_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
    end
  end

  assign out_val = s2_val_q;
  assign out     = out_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire
